// File: rtl/uart_bridge_pkg.sv
// Shared constants, FSM encoding and routing helper for the N-channel UART bridge.
package uart_bridge_pkg;

  localparam logic [1:0] MODE_ECHO = 2'b00;
  localparam logic [1:0] MODE_RING = 2'b01;
  localparam logic [1:0] MODE_DISP = 2'b10;
  localparam logic [1:0] MODE_HALT = 2'b11;

  typedef enum logic [1:0] {
    SCAN = 2'b00,
    XFER = 2'b01,
    SHOW = 2'b10
  } state_e;

  // Destination channel for a byte received on channel i: itself in echo, next channel in ring.
  function automatic int unsigned dst(input logic [1:0] mode, input int unsigned i,
                                      input int unsigned nch);
    if (mode == MODE_RING) return (i + 1 < nch) ? i + 1 : 0;
    return i;
  endfunction

endpackage

// File: rtl/uart.sv
// Oversampling UART core: baud tick, rx/tx serialisers and a FIFO on each side.
module uart #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR     = 163,
  parameter int DVSR_BIT = 8,
  parameter int FIFO_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_uart,
  input  logic            wr_uart,
  input  logic            rx,
  input  logic [DBIT-1:0] w_data,
  output logic            tx_full,
  output logic            rx_empty,
  output logic            rx_full,
  output logic            tx,
  output logic [DBIT-1:0] r_data
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_e;

  logic [DVSR_BIT-1:0] baud_q;
  logic                tick, rx_done, tx_done, tx_empty, tx_q;
  ser_e                rx_st_q, tx_st_q;
  logic [5:0]          rx_s_q, tx_s_q;
  logic [3:0]          rx_n_q, tx_n_q;
  logic [DBIT-1:0]     rx_b_q, tx_b_q, tx_head;

  assign tick    = (baud_q == DVSR_BIT'(DVSR - 1));
  assign rx_done = (rx_st_q == STOP) && tick && (rx_s_q == 6'(SB_TICK - 1));
  assign tx_done = (tx_st_q == STOP) && tick && (tx_s_q == 6'(SB_TICK - 1));
  assign tx      = tx_q;

  // Baud-rate oversample tick generator.
  always_ff @(posedge clk) begin
    if (reset) baud_q <= '0;
    else       baud_q <= tick ? '0 : baud_q + 1'b1;
  end

  // Receiver: find start bit, sample each data bit mid-cell, wait out the stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_st_q <= IDLE;
      rx_s_q  <= '0;
      rx_n_q  <= '0;
      rx_b_q  <= '0;
    end else begin
      case (rx_st_q)
        IDLE: if (!rx) begin rx_st_q <= START; rx_s_q <= '0; end
        START: if (tick) begin
          if (rx_s_q == 6'd7) begin rx_st_q <= DATA; rx_s_q <= '0; rx_n_q <= '0; end
          else rx_s_q <= rx_s_q + 1'b1;
        end
        DATA: if (tick) begin
          if (rx_s_q == 6'd15) begin
            rx_s_q <= '0;
            rx_b_q <= {rx, rx_b_q[DBIT-1:1]};
            if (rx_n_q == 4'(DBIT - 1)) rx_st_q <= STOP;
            else rx_n_q <= rx_n_q + 1'b1;
          end else rx_s_q <= rx_s_q + 1'b1;
        end
        STOP: if (tick) begin
          if (rx_s_q == 6'(SB_TICK - 1)) rx_st_q <= IDLE;
          else rx_s_q <= rx_s_q + 1'b1;
        end
        default: rx_st_q <= IDLE;
      endcase
    end
  end

  // Transmitter: frame the FIFO head byte; the head is popped once its stop bit is done.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st_q <= IDLE;
      tx_s_q  <= '0;
      tx_n_q  <= '0;
      tx_b_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (tx_st_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!tx_empty) begin tx_st_q <= START; tx_s_q <= '0; tx_b_q <= tx_head; end
        end
        START: begin
          tx_q <= 1'b0;
          if (tick) begin
            if (tx_s_q == 6'd15) begin tx_st_q <= DATA; tx_s_q <= '0; tx_n_q <= '0; end
            else tx_s_q <= tx_s_q + 1'b1;
          end
        end
        DATA: begin
          tx_q <= tx_b_q[0];
          if (tick) begin
            if (tx_s_q == 6'd15) begin
              tx_s_q <= '0;
              tx_b_q <= tx_b_q >> 1;
              if (tx_n_q == 4'(DBIT - 1)) tx_st_q <= STOP;
              else tx_n_q <= tx_n_q + 1'b1;
            end else tx_s_q <= tx_s_q + 1'b1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (tick) begin
            if (tx_s_q == 6'(SB_TICK - 1)) tx_st_q <= IDLE;
            else tx_s_q <= tx_s_q + 1'b1;
          end
        end
        default: tx_st_q <= IDLE;
      endcase
    end
  end

  uart_fifo #(.DW(DBIT), .AW(FIFO_W)) u_rx_fifo (
    .clk(clk), .reset(reset), .rd(rd_uart), .wr(rx_done), .w_data(rx_b_q),
    .empty(rx_empty), .full(rx_full), .r_data(r_data)
  );

  uart_fifo #(.DW(DBIT), .AW(FIFO_W)) u_tx_fifo (
    .clk(clk), .reset(reset), .rd(tx_done), .wr(wr_uart), .w_data(w_data),
    .empty(tx_empty), .full(tx_full), .r_data(tx_head)
  );
endmodule

// File: rtl/uart_bridge_ctrl.sv
// Round-robin bridge controller: moves bytes between uart channels or onto the LEDs.
//   state | meaning
//   SCAN  | examine channel ptr (echo/ring) or wait for a step tick (display)
//   XFER  | pop rx[src], push tx[dst], bump transfer count
//   SHOW  | pop rx[sel], latch the byte onto the LEDs
module uart_bridge_ctrl
  import uart_bridge_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int SEL_W = 1,
  parameter int DBIT  = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [1:0]        mode_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              step_i,
  input  logic [NCH-1:0]    rx_empty_i,
  input  logic [NCH-1:0]    tx_full_i,
  input  logic [NCH*DBIT-1:0] r_data_i,
  output logic [NCH-1:0]    rd_uart_o,
  output logic [NCH-1:0]    wr_uart_o,
  output logic [DBIT-1:0]   w_data_o,
  output logic [7:0]        led_o,
  output logic [CNT_W-1:0]  xfer_cnt_o
);
  localparam int PTR_W = (NCH > 2) ? $clog2(NCH) : 1;

  state_e           state_q;
  logic [PTR_W-1:0] ptr_q, src_q, ptr_d, dst_d;
  logic [NCH-1:0]   rd_q, wr_q;
  logic [7:0]       led_q;
  logic [CNT_W-1:0] xfer_cnt_q;
  logic             step_q, step_tick, sel_ready;
  logic [DBIT-1:0]  src_byte;
  logic [7:0]       src_byte8;

  assign ptr_d      = (ptr_q == PTR_W'(NCH - 1)) ? '0 : ptr_q + 1'b1;
  assign dst_d      = PTR_W'(dst(mode_i, 32'(ptr_q), NCH));
  assign step_tick  = step_i & ~step_q;
  assign sel_ready  = ({1'b0, sel_i} < (SEL_W+1)'(NCH)) && !rx_empty_i[sel_i];
  assign src_byte   = r_data_i[src_q*DBIT +: DBIT];
  assign w_data_o   = src_byte;
  assign rd_uart_o  = rd_q;
  assign wr_uart_o  = wr_q;
  assign led_o      = led_q;
  assign xfer_cnt_o = xfer_cnt_q;

  if (DBIT >= 8) begin : g_led_wide
    assign src_byte8 = src_byte[7:0];
  end else begin : g_led_narrow
    assign src_byte8 = {{(8-DBIT){1'b0}}, src_byte};
  end

  // Bridge FSM; strobes are registered one-hot so they are live exactly in XFER/SHOW.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= SCAN;
      ptr_q      <= '0;
      src_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      led_q      <= '0;
      xfer_cnt_q <= '0;
      step_q     <= 1'b0;
    end else begin
      step_q <= step_i;
      rd_q   <= '0;
      wr_q   <= '0;
      case (state_q)
        SCAN: begin
          if (mode_i == MODE_ECHO || mode_i == MODE_RING) begin
            if (!rx_empty_i[ptr_q] && !tx_full_i[dst_d]) begin
              state_q <= XFER;
              src_q   <= ptr_q;
              rd_q    <= NCH'(1) << ptr_q;
              wr_q    <= NCH'(1) << dst_d;
            end else begin
              ptr_q <= ptr_d;
            end
          end else if (mode_i == MODE_DISP && step_tick && sel_ready) begin
            state_q <= SHOW;
            src_q   <= PTR_W'(sel_i);
            rd_q    <= NCH'(1) << sel_i;
          end
        end
        XFER: begin
          if (xfer_cnt_q != '1) xfer_cnt_q <= xfer_cnt_q + 1'b1;
          ptr_q   <= ptr_d;
          state_q <= SCAN;
        end
        SHOW: begin
          led_q   <= src_byte8;
          state_q <= SCAN;
        end
        default: state_q <= SCAN;
      endcase
    end
  end
endmodule

// File: rtl/uart_fifo.sv
// Show-ahead FIFO used for the rx and tx paths of each uart core.
module uart_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] w_data,
  output logic          empty,
  output logic          full,
  output logic [DW-1:0] r_data
);
  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          wr_en, rd_en;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == (AW+1)'(2**AW));
  assign wr_en  = wr & ~full;
  assign rd_en  = rd & ~empty;
  assign r_data = mem_q[rp_q];

  // Storage array; contents need no reset since cnt_q gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= w_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(wr_en);
      rp_q  <= rp_q + AW'(rd_en);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
endmodule

// File: rtl/uart_bridge_nch.sv
// Board top: NCH uart cores joined by the round-robin bridge controller.
module uart_bridge_nch
  import uart_bridge_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int SEL_W    = 1,
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR     = 163,
  parameter int DVSR_BIT = 8,
  parameter int FIFO_W   = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   rx,
  output logic [NCH-1:0]   tx,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             step,
  output logic [NCH-1:0]   rx_empty,
  output logic [NCH-1:0]   rx_full,
  output logic [NCH-1:0]   tx_full,
  output logic [7:0]       led,
  output logic [CNT_W-1:0] xfer_cnt
);
  logic [NCH-1:0]      rd_uart, wr_uart;
  logic [DBIT-1:0]     w_data;
  logic [NCH*DBIT-1:0] r_data;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    uart #(
      .DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR), .DVSR_BIT(DVSR_BIT), .FIFO_W(FIFO_W)
    ) u_uart (
      .clk(clk), .reset(reset), .rd_uart(rd_uart[i]), .wr_uart(wr_uart[i]), .rx(rx[i]),
      .w_data(w_data), .tx_full(tx_full[i]), .rx_empty(rx_empty[i]), .rx_full(rx_full[i]),
      .tx(tx[i]), .r_data(r_data[i*DBIT +: DBIT])
    );
  end

  uart_bridge_ctrl #(.NCH(NCH), .SEL_W(SEL_W), .DBIT(DBIT), .CNT_W(CNT_W)) u_ctrl (
    .clk_i(clk), .reset_i(reset), .mode_i(mode), .sel_i(sel), .step_i(step),
    .rx_empty_i(rx_empty), .tx_full_i(tx_full), .r_data_i(r_data),
    .rd_uart_o(rd_uart), .wr_uart_o(wr_uart), .w_data_o(w_data),
    .led_o(led), .xfer_cnt_o(xfer_cnt)
  );
endmodule

// File: tb/tb_uart_bridge_nch.sv
// Bench for uart_bridge_nch: a 2-channel and a 3-channel (2-bit counter) instance.
module tb_uart_bridge_nch;
  import uart_bridge_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset2, reset3, sel2, step2, step3;
  logic [1:0]  rx2, tx2, rxe2, rxf2, txf2, mode2, mode3, sel3, cnt3;
  logic [2:0]  rx3, tx3, rxe3, rxf3, txf3;
  logic [7:0]  led2, led3;
  logic [15:0] cnt2;
  logic [4:0]  tx_all;
  assign tx_all = {tx3, tx2};

  uart_bridge_nch #(.NCH(2), .SEL_W(1), .DVSR(1), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset2), .rx(rx2), .tx(tx2), .mode(mode2), .sel(sel2), .step(step2),
    .rx_empty(rxe2), .rx_full(rxf2), .tx_full(txf2), .led(led2), .xfer_cnt(cnt2));

  uart_bridge_nch #(.NCH(3), .SEL_W(2), .DVSR(1), .CNT_W(2)) u3 (
    .clk(clk), .reset(reset3), .rx(rx3), .tx(tx3), .mode(mode3), .sel(sel3), .step(step3),
    .rx_empty(rxe3), .rx_full(rxf3), .tx_full(txf3), .led(led3), .xfer_cnt(cnt3));

  int checks = 0, errors = 0;
  int strobe_viol = 0, bp_viol = 0;
  bit saw_full = 0;
  logic [7:0] rxq [5][$];   // lines 0-1: u2 tx, lines 2-4: u3 tx

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int d, input int ch, input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (d == 0) rx2[ch] = fr[i]; else rx3[ch] = fr[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic wait_q(input string name, input int k, input int n, input int budget);
    int c;
    c = 0;
    while (rxq[k].size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(name, rxq[k].size() >= n, 1);
  endtask

  function automatic int total_q();
    int s;
    s = 0;
    for (int k = 0; k < 5; k++) s += rxq[k].size();
    return s;
  endfunction

  task automatic clear_q();
    for (int k = 0; k < 5; k++) rxq[k].delete();
  endtask

  // Serial decoders, one per tx line, sampling mid-bit on the falling clock edge.
  for (genvar k = 0; k < 5; k++) begin : g_mon
    initial begin
      logic [7:0] b;
      b = '0;
      forever begin
        @(negedge clk);
        if (tx_all[k] === 1'b0) begin
          repeat (8) @(negedge clk);
          for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            b[i] = tx_all[k];
          end
          repeat (16) @(negedge clk);
          rxq[k].push_back(b);
        end
      end
    end
  end

  // Strobe exclusivity and backpressure watch.
  always @(negedge clk) begin
    if (!$onehot0(u2.rd_uart) || !$onehot0(u2.wr_uart) ||
        !$onehot0(u3.rd_uart) || !$onehot0(u3.wr_uart)) strobe_viol++;
    if (u2.wr_uart[0] && txf2[0]) bp_viol++;
    if (txf2[0]) saw_full = 1;
  end

  typedef struct {
    int         d;
    logic [1:0] mode;
    int         ch;
    logic [7:0] data;
    int         line;
    int         cnt;
  } vec_t;

  vec_t vt[6];

  initial begin
    int c;
    vt[0] = '{0, MODE_ECHO, 0, 8'hA5, 0, 1};
    vt[1] = '{0, MODE_ECHO, 1, 8'h5A, 1, 2};
    vt[2] = '{0, MODE_RING, 0, 8'h3C, 1, 3};
    vt[3] = '{0, MODE_RING, 1, 8'hC3, 0, 4};
    vt[4] = '{1, MODE_RING, 2, 8'h11, 2, 1};
    vt[5] = '{1, MODE_ECHO, 1, 8'h96, 3, 2};

    reset2 = 1; reset3 = 1; rx2 = '1; rx3 = '1;
    mode2 = MODE_ECHO; mode3 = MODE_ECHO; sel2 = 0; sel3 = 0; step2 = 0; step3 = 0;
    repeat (4) @(negedge clk);
    reset2 = 0; reset3 = 0;
    @(negedge clk);
    chk("rst led2", led2, 0);
    chk("rst cnt2", cnt2, 0);
    chk("rst tx2", tx2, 2'b11);
    chk("rst rxe2", rxe2, 2'b11);
    chk("rst cnt3", cnt3, 0);
    chk("rst tx3", tx3, 3'b111);
    chk("rst rxe3", rxe3, 3'b111);

    // Table: single byte routed by echo/ring, exactly one tx line carries it.
    for (int v = 0; v < 6; v++) begin
      clear_q();
      if (vt[v].d == 0) mode2 = vt[v].mode; else mode3 = vt[v].mode;
      send(vt[v].d, vt[v].ch, vt[v].data);
      wait_q($sformatf("vec%0d arrive", v), vt[v].line, 1, 600);
      repeat (200) @(negedge clk);
      if (rxq[vt[v].line].size() > 0) chk($sformatf("vec%0d data", v), rxq[vt[v].line][0], vt[v].data);
      chk($sformatf("vec%0d lines", v), total_q(), 1);
      chk($sformatf("vec%0d cnt", v), (vt[v].d == 0) ? 32'(cnt2) : 32'(cnt3), vt[v].cnt);
    end

    // Ring order on u3 rx[1] -> tx[2]; five transfers saturate the 2-bit counter.
    clear_q();
    mode3 = MODE_RING;
    send(1, 1, 8'h01); send(1, 1, 8'h02); send(1, 1, 8'h03);
    wait_q("ring3 arrive", 4, 3, 800);
    for (int i = 0; i < 3; i++)
      if (rxq[4].size() > i) chk($sformatf("ring3 byte%0d", i), rxq[4][i], i + 1);
    chk("ring3 lines", total_q(), 3);
    chk("cnt3 saturate", cnt3, 3);

    // Halt holds the byte; ring resumes within 2*NCH cycles.
    clear_q();
    mode3 = MODE_HALT;
    send(1, 0, 8'h42);
    repeat (40) @(negedge clk);
    chk("halt rxe3[0]", rxe3[0], 0);
    chk("halt tx3 idle", tx3, 3'b111);
    mode3 = MODE_RING;
    c = 0;
    while (rxe3[0] == 1'b0 && c < 20) begin @(negedge clk); c++; end
    chk("resume latency ok", c <= 6, 1);
    wait_q("resume arrive", 3, 1, 600);
    if (rxq[3].size() > 0) chk("resume data", rxq[3][0], 8'h42);
    chk("halt cnt3", cnt3, 3);

    // Display on u2 channel 1: one tick per press, ticks on empty FIFO are dropped.
    clear_q();
    mode2 = MODE_DISP; sel2 = 1;
    send(0, 1, 8'h3C); send(0, 1, 8'hC3);
    repeat (20) @(negedge clk);
    chk("disp before press", led2, 0);
    step2 = 1; repeat (100) @(negedge clk);
    chk("disp press1", led2, 8'h3C);
    chk("disp single tick", rxe2[1], 0);
    step2 = 0; repeat (10) @(negedge clk);
    step2 = 1; repeat (100) @(negedge clk);
    chk("disp press2", led2, 8'hC3);
    step2 = 0; repeat (10) @(negedge clk);
    step2 = 1; repeat (20) @(negedge clk);
    chk("disp press3 empty", led2, 8'hC3);
    send(0, 1, 8'h77);
    repeat (10) @(negedge clk);
    chk("disp tick not queued", led2, 8'hC3);
    step2 = 0; repeat (10) @(negedge clk);
    step2 = 1; repeat (20) @(negedge clk);
    chk("disp press4", led2, 8'h77);
    step2 = 0;
    chk("disp cnt2", cnt2, 4);
    chk("disp no tx", total_q(), 0);

    // Backpressure: four bytes queued in halt overrun the tx FIFO once echo starts.
    clear_q();
    mode2 = MODE_HALT;
    send(0, 0, 8'h10); send(0, 0, 8'h20); send(0, 0, 8'h30); send(0, 0, 8'h40);
    repeat (5) @(negedge clk);
    chk("bp rx_full", rxf2[0], 1);
    saw_full = 0;
    mode2 = MODE_ECHO;
    send(0, 0, 8'h50);
    wait_q("bp arrive", 0, 5, 2000);
    for (int i = 0; i < 5; i++)
      if (rxq[0].size() > i) chk($sformatf("bp byte%0d", i), rxq[0][i], 8'h10 * (i + 1));
    chk("bp saw tx_full", saw_full, 1);
    chk("bp cnt2", cnt2, 9);

    // Reset landing on an XFER cycle aborts the write.
    clear_q();
    fork send(0, 0, 8'h99); join_none
    c = 0;
    while (u2.u_ctrl.state_q != XFER && c < 400) begin @(negedge clk); c++; end
    chk("reach xfer", c < 400, 1);
    reset2 = 1;
    @(negedge clk);
    chk("mid rst led2", led2, 0);
    chk("mid rst cnt2", cnt2, 0);
    chk("mid rst tx2", tx2, 2'b11);
    chk("mid rst rxe2", rxe2, 2'b11);
    reset2 = 0;
    repeat (400) @(negedge clk);
    chk("mid rst no tx", total_q(), 0);

    chk("strobe onehot", strobe_viol, 0);
    chk("no wr while full", bp_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_bridge_nch.md
Name: uart_bridge_nch

Overview:
- Parametrised N-channel UART bridge and test harness; successor to the two-channel dual-UART board test.
- Instantiates NCH existing `uart` cores.
- A round-robin controller moves received bytes between channels according to a run-time mode: echo, ring-forward, or button-stepped display of one channel onto 8 LEDs.
- Used as the board-level top for link bring-up.

Parameters:
- NCH, 2, number of UART channels (2..8).
- SEL_W, 1, width of display channel select; must satisfy 2**SEL_W >= NCH.
- DBIT, 8, data bits per UART frame.
- SB_TICK, 16, stop-bit oversample ticks.
- DVSR, 163, baud divisor passed to each uart.
- DVSR_BIT, 8, divisor counter width.
- FIFO_W, 2, log2 FIFO depth per uart.
- CNT_W, 16, transfer counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx  in  NCH  serial inputs, one bit per channel
- tx  out  NCH  serial outputs, one bit per channel
- mode  in  2  00 = echo, 01 = ring, 10 = display, 11 = halt
- sel  in  SEL_W  display-channel select (mode 10 only)
- step  in  1  already-debounced push-button level
- rx_empty  out  NCH  per-channel uart rx_empty
- rx_full  out  NCH  per-channel uart rx_full
- tx_full  out  NCH  per-channel uart tx_full
- led  out  8  last byte captured in display mode, led[7] = bit 7
- xfer_cnt  out  CNT_W  saturating count of completed forwards

Behaviour:
- Reset:
  - led = 0, xfer_cnt = 0, ptr = 0, state = SCAN.
  - All internal rd_uart/wr_uart = 0.
  - uart cores reset; tx idles at 1.
- uart read interface is show-ahead: r_data is valid whenever rx_empty = 0; rd_uart pops the byte.
- Destination function dst(i):
  - echo: i.
  - ring: (i+1) mod NCH.
- FSM states: SCAN, XFER, SHOW.
- SCAN, examining channel ptr:
  - mode 00/01: if !rx_empty[ptr] && !tx_full[dst(ptr)] -> XFER; else ptr <= ptr+1 (wraps NCH-1 -> 0), stay in SCAN.
  - mode 10: if step_tick && !rx_empty[sel] -> SHOW; else stay in SCAN, ptr unchanged.
  - mode 11: stay in SCAN; no reads, no writes.
- XFER, exactly one cycle:
  - rd_uart[ptr] = 1 and wr_uart[dst(ptr)] = 1; w_data[dst] = r_data[ptr].
  - xfer_cnt += 1, saturating at all-ones.
  - ptr <= ptr+1; -> SCAN.
- SHOW, exactly one cycle:
  - rd_uart[sel] = 1; led <= r_data[sel] (low 8 bits; zero-extended if DBIT < 8).
  - -> SCAN. xfer_cnt unchanged.
- step_tick:
  - One-cycle pulse on the 0->1 edge of step, via an internal registered copy of step.
  - A held button produces a single tick.
  - A tick arriving outside SCAN, or while rx_empty[sel] = 1, is discarded (not queued).
- Mode and sel are sampled only in SCAN. A change during XFER/SHOW takes effect the next cycle.
- Echo with tx_full set:
  - The byte stays in the rx FIFO and ptr advances; the channel is retried on the next lap.
  - A byte lost to rx FIFO overflow is the uart's behaviour; the bridge does not count it.
- Ordering: bytes from one source channel reach the destination in arrival order. With NCH = 2 in ring mode, the two channels forward concurrently in alternation.
- Latency: from rx_empty[i] falling (destination not full) to wr_uart[dst(i)], at most 2*NCH cycles.
- Fairness: one byte per channel per lap; no channel is starved.
- Reset mid-XFER: the write is aborted and the FIFOs are cleared by the uart reset.
- Never assert more than one rd_uart or wr_uart bit in any cycle.

Decomposition:
- Package uart_bridge_pkg:
  - Mode constants MODE_ECHO, MODE_RING, MODE_DISP, MODE_HALT.
  - FSM state encoding.
  - dst() helper function.
- Sub-module uart_bridge_ctrl: FSM, ptr, step edge detector, led and xfer_cnt registers.
- Top: generate loop of NCH `uart` instances plus uart_bridge_ctrl.

Test Plan:
- All runs use DVSR = 1 in simulation.
- Echo, NCH = 2: send 0xA5 on rx[0] -> 0xA5 framed on tx[0]; tx[1] stays 1; xfer_cnt = 1.
- Ring, NCH = 3: send 0x11 on rx[2] -> 0x11 on tx[0] only; bytes 0x01, 0x02, 0x03 on rx[1] -> emerge in that order on tx[2].
- Display: mode = 10, sel = 1, send 0x3C then 0xC3 on rx[1], hold step high 100 cycles -> led = 0x3C after one tick; second press -> led = 0xC3; third press with FIFO empty -> led stays 0xC3.
- Backpressure: fill tx FIFO of ch0 (echo, 4 bytes burst plus 1) -> no wr_uart while tx_full[0]; every byte eventually echoed in order; no two rd or wr bits high in one cycle (assertion).
- Halt / mode change: mode = 11 with data pending -> rx_empty stays 0, tx idle; switch to 01 -> forwarding resumes within 2*NCH cycles.
- Reset / saturation: assert reset during XFER -> next cycle led = 0, xfer_cnt = 0, tx = all ones; with CNT_W = 2 and 5 transfers -> xfer_cnt = 3.
